mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between the instruction-fetch requester (pre_if side) and the
//  data requester (mem stage). Fixed priority favours data, bounded by a starvation counter.
//  Allows one outstanding transaction; the response is routed back to the owning requester.
//  Sits between the core's fetch/mem stages and the rom/ram bus wrapper.
// PARAMETERS
//  ADDR_W        32  address width (matches `BUS_WIDTH)
//  DATA_W        32  data width (matches `DATA_WIDTH)
//  STARVE_LIMIT  4   max consecutive data grants while an instruction request is pending
// PORTS
//  clk          in   1        clock, all state on posedge
//  rst_n        in   1        asynchronous active-low reset
//  i_req        in   1        fetch read request
//  i_addr       in   ADDR_W   fetch address
//  i_addr_ok    out  1        fetch request accepted this cycle
//  i_data_ok    out  1        fetch response valid
//  i_rdata      out  DATA_W   fetch read data
//  d_req        in   1        data request
//  d_we         in   1        1 = write, 0 = read
//  d_addr       in   ADDR_W   data address
//  d_wdata      in   DATA_W   write data
//  d_wstrb      in   DATA_W/8 byte strobes
//  d_addr_ok    out  1        data request accepted this cycle
//  d_data_ok    out  1        data response valid (read data, or write done)
//  d_rdata      out  DATA_W   data read data
//  m_req        out  1        bus request
//  m_we         out  1        bus write enable; forced 0 for a fetch
//  m_addr       out  ADDR_W   bus address
//  m_wdata      out  DATA_W   bus write data
//  m_wstrb      out  DATA_W/8 bus strobes; forced 0 for a fetch
//  m_addr_ok    in   1        bus accepted request
//  m_data_ok    in   1        bus response valid; arrives 1+ cycles after acceptance
//  m_rdata      in   DATA_W   bus read data
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, starve_cnt=0; with no request, every output is 0 (rdata follows m_rdata).
//  - States:
//    * IDLE: no transaction outstanding.
//    * BUSY: one transaction outstanding; registered owner is I or D.
//  - Issue window: IDLE, or BUSY in a cycle with m_data_ok=1. Outside the window m_req=0 and both addr_ok=0.
//  - Grant (combinational, inside issue window):
//    * sel_i = i_req && (!d_req || starve_cnt==STARVE_LIMIT); sel_d = d_req && !sel_i.
//    * m_req = sel_i|sel_d; m_* muxed from the selected requester.
//    * i_addr_ok = sel_i&m_addr_ok; d_addr_ok = sel_d&m_addr_ok.
//  - Transitions:
//    * Acceptance (m_req&m_addr_ok): state=BUSY, owner=selected requester.
//    * BUSY with m_data_ok and no new acceptance: back to IDLE. Back-to-back issue needs no bubble.
//  - Response: i_data_ok = BUSY&owner==I&m_data_ok; d_data_ok likewise for D. rdata = m_rdata to both.
//  - starve_cnt (saturating, 0..STARVE_LIMIT):
//    * +1 on each accepted data grant while i_req=1.
//    * Cleared on an accepted fetch grant, or whenever i_req=0.
//    * Holds when no grant is accepted.
//  - Requesters hold req/addr/data stable until their addr_ok. Dropping a req before acceptance is legal; there is no penalty.
//  - m_data_ok in IDLE is a protocol error: ignored, no data_ok is raised.
//  - A fetch cancel upstream does not abort the bus. The response is still delivered; discarding it is the requester's job.
//  - Reset asserted mid-transaction: state returns to IDLE at once. Any later m_data_ok is dropped per the rule above.
// TESTING
//  1. Reset, i_req=1 addr=0x0, m_addr_ok=1, m_data_ok 2 cyc later with rdata=0x00000013
//     -> i_addr_ok=1 in cycle 0; i_data_ok=1 with i_rdata=0x13 in cycle 2; d_data_ok stays 0.
//  2. i_req and d_req both high in IDLE, starve_cnt=0 -> D granted (m_we=d_we, m_addr=d_addr); i_addr_ok=0.
//  3. d_req held high, i_req held high, m_addr_ok=m_data_ok=1 every cycle
//     -> grants D,D,D,D,I,D,D,D,D,I... (STARVE_LIMIT=4).
//  4. Fetch in BUSY, d_req rises in the same cycle as m_data_ok
//     -> i_data_ok=1 and d_addr_ok=1 in that cycle; next m_data_ok goes to D.
//  5. Write d_we=1 wstrb=0x3 addr=0x100 -> m_wstrb=0x3, m_we=1; a fetch grant drives m_we=0, m_wstrb=0.
//  6. rst_n low while BUSY, stray m_data_ok after release -> no data_ok pulse; next i_req granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the memory bus wrapper.
// The arbiter uses the master view; the requesters and the bus wrapper sit on the slave view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic                i_unused_pad;
  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                d_addr_ok;
  logic                d_data_ok;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_addr_ok;
  logic                m_data_ok;
  logic [DATA_W-1:0]   m_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_addr_ok, m_data_ok, m_rdata,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           m_addr_ok, m_data_ok, m_rdata,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for a single-port memory bus: data has priority, bounded by a starvation
// counter; one transaction outstanding, response routed back to the owning requester.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_bus_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] starve, starve_nxt;

  logic win, sel_i, sel_d, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= OWN_I;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve;

    // A new request may go out while idle, or in the cycle the outstanding one completes.
    win    = (state == IDLE) || bus.m_data_ok;
    sel_i  = win && bus.i_req && (!bus.d_req || starve == CNT_W'(STARVE_LIMIT));
    sel_d  = win && bus.d_req && !sel_i;
    accept = (sel_i || sel_d) && bus.m_addr_ok;

    if (accept) begin
      state_nxt = BUSY;
      owner_nxt = sel_d ? OWN_D : OWN_I;
    end else if (state == BUSY && bus.m_data_ok) begin
      state_nxt = IDLE;
    end

    if (!bus.i_req || (accept && sel_i))
      starve_nxt = '0;
    else if (accept && sel_d && starve != CNT_W'(STARVE_LIMIT))
      starve_nxt = starve + CNT_W'(1);
  end

  assign bus.m_req   = sel_i || sel_d;
  assign bus.m_we    = sel_d && bus.d_we;
  assign bus.m_addr  = sel_d ? bus.d_addr : (sel_i ? bus.i_addr : '0);
  assign bus.m_wdata = sel_d ? bus.d_wdata : '0;
  assign bus.m_wstrb = sel_d ? bus.d_wstrb : '0;

  assign bus.i_addr_ok = sel_i && bus.m_addr_ok;
  assign bus.d_addr_ok = sel_d && bus.m_addr_ok;

  // A stray m_data_ok while idle is dropped here.
  assign bus.i_data_ok = (state == BUSY) && (owner == OWN_I) && bus.m_data_ok;
  assign bus.d_data_ok = (state == BUSY) && (owner == OWN_D) && bus.m_data_ok;
  assign bus.i_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge, outputs are checked
// shortly after, well before the next rising edge.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); #1;
    checks++;
    if ({bus.m_req, bus.m_we, bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {bus.m_req, bus.m_we, bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok});
    end
    checks++;
    if ({bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 68'h0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {bus.m_addr, bus.m_wdata, bus.m_wstrb});
    end
    rst_n = 1;
  endtask

  task automatic test_fetch();
    cyc(); bus.i_req = 1; bus.i_addr = 32'h0; bus.m_addr_ok = 1; #1;
    checks++;
    if ({bus.m_req, bus.i_addr_ok, bus.d_addr_ok, bus.m_we} !== 4'b1100) begin
      errors++; $display("FAIL fetch_issue got %b want 1100", {bus.m_req, bus.i_addr_ok, bus.d_addr_ok, bus.m_we});
    end
    cyc(); bus.i_req = 0; bus.m_addr_ok = 0; #1;
    checks++;
    if ({bus.m_req, bus.i_data_ok, bus.d_data_ok} !== 3'b000) begin
      errors++; $display("FAIL fetch_wait got %b want 000", {bus.m_req, bus.i_data_ok, bus.d_data_ok});
    end
    cyc(); bus.m_data_ok = 1; bus.m_rdata = 32'h13; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok, bus.i_rdata} !== {2'b10, 32'h13}) begin
      errors++; $display("FAIL fetch_resp got %b/%h want 10/00000013", {bus.i_data_ok, bus.d_data_ok}, bus.i_rdata);
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_priority();
    cyc();
    bus.i_req = 1; bus.i_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hCAFE0001; bus.d_wstrb = 4'hF;
    bus.m_addr_ok = 0; #1;
    checks++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.i_addr_ok, bus.d_addr_ok} !== {2'b11, 32'h200, 2'b00}) begin
      errors++; $display("FAIL prio_mux got %b %h %b want 11 00000200 00",
        {bus.m_req, bus.m_we}, bus.m_addr, {bus.i_addr_ok, bus.d_addr_ok});
    end
    bus.m_addr_ok = 1; #1;
    checks++;
    if ({bus.i_addr_ok, bus.d_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL prio_grant got %b want 01", {bus.i_addr_ok, bus.d_addr_ok});
    end
    cyc(); idle_inputs(); bus.m_data_ok = 1; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok, bus.m_req} !== 3'b010) begin
      errors++; $display("FAIL prio_resp got %b want 010", {bus.i_data_ok, bus.d_data_ok, bus.m_req});
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_starvation();
    logic prev_i;
    prev_i = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.i_req = 1; bus.i_addr = 32'h80; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
      bus.m_addr_ok = 1; bus.m_data_ok = 1; bus.m_rdata = k; #1;
      checks++;
      if ({bus.i_addr_ok, bus.d_addr_ok} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_grant%0d got %b want %b", k, {bus.i_addr_ok, bus.d_addr_ok},
          (k % 5 == 4) ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        checks++;
        if ({bus.i_data_ok, bus.d_data_ok} !== {prev_i, !prev_i}) begin
          errors++; $display("FAIL starve_resp%0d got %b want %b", k, {bus.i_data_ok, bus.d_data_ok}, {prev_i, !prev_i});
        end
      end
      prev_i = (k % 5 == 4);
    end
    cyc(); idle_inputs(); bus.m_data_ok = 1;
    cyc(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    cyc(); bus.i_req = 1; bus.i_addr = 32'h10; bus.m_addr_ok = 1; #1;
    checks++;
    if (bus.i_addr_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_fetch got %b want 1", bus.i_addr_ok);
    end
    cyc(); bus.i_req = 0; bus.d_req = 1; bus.d_addr = 32'h300;
    bus.m_data_ok = 1; bus.m_rdata = 32'hAA; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok, bus.d_addr_ok, bus.m_addr} !== {3'b101, 32'h300}) begin
      errors++; $display("FAIL b2b_overlap got %b %h want 101 00000300",
        {bus.i_data_ok, bus.d_data_ok, bus.d_addr_ok}, bus.m_addr);
    end
    cyc(); bus.d_req = 0; bus.m_addr_ok = 0; bus.m_rdata = 32'h55; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok, bus.d_rdata} !== {2'b01, 32'h55}) begin
      errors++; $display("FAIL b2b_dresp got %b %h want 01 00000055", {bus.i_data_ok, bus.d_data_ok}, bus.d_rdata);
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_write_mux();
    cyc(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678;
    bus.d_wstrb = 4'h3; bus.m_addr_ok = 1; #1;
    checks++;
    if ({bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.d_addr_ok} !== {1'b1, 4'h3, 32'h100, 32'h12345678, 1'b1}) begin
      errors++; $display("FAIL write_mux got %b %h %h %h %b want 1 3 00000100 12345678 1",
        bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.d_addr_ok);
    end
    cyc(); bus.d_req = 0; bus.i_req = 1; bus.i_addr = 32'h104; bus.m_data_ok = 1; #1;
    checks++;
    if ({bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.i_addr_ok, bus.d_data_ok} !== {1'b0, 4'h0, 32'h104, 32'h0, 2'b11}) begin
      errors++; $display("FAIL fetch_mux got %b %h %h %h %b want 0 0 00000104 00000000 11",
        bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, {bus.i_addr_ok, bus.d_data_ok});
    end
    cyc(); idle_inputs(); bus.m_data_ok = 1; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok} !== 2'b10) begin
      errors++; $display("FAIL fetch_done got %b want 10", {bus.i_data_ok, bus.d_data_ok});
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_reset_midflight();
    cyc(); bus.i_req = 1; bus.i_addr = 32'h20; bus.m_addr_ok = 1;
    cyc(); idle_inputs(); rst_n = 0; bus.m_data_ok = 1; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok, bus.m_req} !== 3'b000) begin
      errors++; $display("FAIL rst_busy got %b want 000", {bus.i_data_ok, bus.d_data_ok, bus.m_req});
    end
    cyc(); rst_n = 1;
    cyc(); bus.m_data_ok = 1; bus.m_rdata = 32'hDEAD; #1;
    checks++;
    if ({bus.i_data_ok, bus.d_data_ok} !== 2'b00) begin
      errors++; $display("FAIL rst_stray got %b want 00", {bus.i_data_ok, bus.d_data_ok});
    end
    cyc(); bus.m_data_ok = 0; bus.i_req = 1; bus.i_addr = 32'h24; bus.m_addr_ok = 1; #1;
    checks++;
    if ({bus.m_req, bus.i_addr_ok, bus.m_addr} !== {2'b11, 32'h24}) begin
      errors++; $display("FAIL rst_regrant got %b %h want 11 00000024", {bus.m_req, bus.i_addr_ok}, bus.m_addr);
    end
    cyc(); idle_inputs(); bus.m_data_ok = 1; #1;
    checks++;
    if (bus.i_data_ok !== 1'b1) begin
      errors++; $display("FAIL rst_resp got %b want 1", bus.i_data_ok);
    end
    cyc(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_back_to_back();
    test_write_mux();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
